// File: rtl/serial_ripple_subtractor_if.sv
// Handshake and operand/result bundle for the bit-serial subtractor.
// master drives the request side; slave is the subtractor itself.
interface serial_ripple_subtractor_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Bin;
    logic [WIDTH-1:0] D;
    logic             Bout;
    logic             busy;
    logic             done;

    modport master (
        output start, A, B, Bin,
        input  D, Bout, busy, done
    );

    modport slave (
        input  start, A, B, Bin,
        output D, Bout, busy, done
    );
endinterface

// File: rtl/serial_ripple_subtractor.sv
// Bit-serial subtractor: D = A - B - Bin, one bit per clock, LSB first,
// with a single borrow flop rippling between successive bit slices.
//
// state | meaning
// IDLE  | waiting for start; D/Bout hold the last result
// RUN   | one bit processed per edge, counter = bit index
// DONE  | done pulse for one cycle, D/Bout valid
module serial_ripple_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    serial_ripple_subtractor_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic             br;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] d_reg;
    logic             bout_reg;

    logic             accept;
    logic             step;
    logic             last_bit;
    logic             d_bit;
    logic             br_nxt;
    logic [WIDTH-1:0] res_nxt;

    // One full-subtractor slice on the current LSBs
    assign d_bit    = a_sr[0] ^ b_sr[0] ^ br;
    assign br_nxt   = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);
    assign res_nxt  = {d_bit, res_sr[WIDTH-1:1]};
    assign last_bit = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        step      = 1'b0;
        bus.busy  = 1'b0;
        bus.done  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                bus.busy = 1'b1;
                step     = 1'b1;
                if (last_bit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                bus.busy  = 1'b1;
                bus.done  = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            br     <= 1'b0;
            cnt    <= '0;
        end else if (accept) begin
            a_sr   <= bus.A;
            b_sr   <= bus.B;
            br     <= bus.Bin;
            res_sr <= '0;
            cnt    <= '0;
        end else if (step) begin
            a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
            b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
            br     <= br_nxt;
            res_sr <= res_nxt;
            if (!last_bit) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Visible result only moves on the DONE-entry edge, so it is stable through IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_reg    <= '0;
            bout_reg <= 1'b0;
        end else if (step && last_bit) begin
            d_reg    <= res_nxt;
            bout_reg <= br_nxt;
        end
    end

    assign bus.D    = d_reg;
    assign bus.Bout = bout_reg;

    a_done_single: assert property (@(posedge clk) disable iff (!rst_n)
        bus.done |=> !bus.done);
    a_done_to_idle: assert property (@(posedge clk) disable iff (!rst_n)
        (state == DONE) |=> (state == IDLE));
    a_result_stable_idle: assert property (@(posedge clk) disable iff (!rst_n)
        (state == IDLE) |=> $stable(bus.D) && $stable(bus.Bout));
endmodule
